ann_seq_ctrl: RTL and testbench

ANN_SEQ_CTRL -- requirements
Module: ann_seq_ctrl

---
 rtl/ann_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_ann_seq_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ann_seq_ctrl.sv
// Sequencer for a two-layer ANN training datapath. It steers the W1/W2/data/
// target input streams into their buffers, then walks one training step
// (forward, output, error, weight updates) as a series of datapath ops with
// exactly one op outstanding at a time.
module ann_seq_ctrl #(
  parameter int N_IN  = 4,
  parameter int N_HID = 3,
  localparam int N_W1  = N_IN * N_HID,
  localparam int W1_AW = (N_W1  > 1) ? $clog2(N_W1)  : 1,
  localparam int HID_W = (N_HID > 1) ? $clog2(N_HID) : 1,
  localparam int IN_W  = (N_IN  > 1) ? $clog2(N_IN)  : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_w1,
  input  logic             in_valid_w2,
  input  logic             in_valid_d,
  input  logic             in_valid_t,
  output logic             w1_we,
  output logic [W1_AW-1:0] w1_addr,
  output logic             w2_we,
  output logic [HID_W-1:0] w2_addr,
  output logic             d_we,
  output logic [IN_W-1:0]  d_addr,
  output logic             t_we,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [2:0]       op_code,
  output logic [HID_W-1:0] op_row,
  output logic [IN_W-1:0]  op_col,
  output logic             op_first,
  input  logic             res_valid,
  output logic             out_valid,
  output logic             busy,
  output logic             err
);

  // Counters must be able to hold their limit, so they are one value wider
  // than the largest address.
  localparam int CNT_W = $clog2(N_W1 + 1);

  localparam logic [2:0] OP_MAC1 = 3'd0;
  localparam logic [2:0] OP_ACT  = 3'd1;
  localparam logic [2:0] OP_MAC2 = 3'd2;
  localparam logic [2:0] OP_ERR  = 3'd3;
  localparam logic [2:0] OP_UPD2 = 3'd4;
  localparam logic [2:0] OP_UPD1 = 3'd5;

  localparam logic [HID_W-1:0] ROW_LAST = HID_W'(N_HID - 1);
  localparam logic [IN_W-1:0]  COL_LAST = IN_W'(N_IN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_FWD1, S_ACT, S_FWD2, S_OUT, S_BWD_ERR, S_UPD2, S_UPD1
  } state_t;

  state_t           state_reg, state_next, after_state;
  logic [HID_W-1:0] row_reg, row_next;
  logic [IN_W-1:0]  col_reg, col_next;
  logic             outstanding_reg;
  logic             weights_ok_reg;
  logic             err_reg, err_next;
  logic [3:0]       valid_prev_reg;

  logic                  load_window, clear_sample, discard;
  logic [3:0]            in_valid_vec, we_vec, over_vec;
  logic [3:0][CNT_W-1:0] cnt_vec, eff_vec;
  logic                  w1_full, w2_full, weights_full, sample_ready;
  logic                  op_active, op_matrix, op_single, phase_last;
  logic [2:0]            code_sel;
  logic                  first_sel;
  logic                  fire, res_hit;

  // Stream index: 0 = W1, 1 = W2, 2 = data point, 3 = target.
  assign in_valid_vec = {in_valid_t, in_valid_d, in_valid_w2, in_valid_w1};
  assign load_window  = (state_reg == S_IDLE) || (state_reg == S_LOAD);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_stream
      localparam int LIMIT = (gi == 0) ? N_W1 : (gi == 1) ? N_HID : (gi == 2) ? N_IN : 1;
      localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
      // Data and target belong to one sample and are consumed with it;
      // weights persist across samples.
      localparam bit PER_SAMPLE = (gi >= 2);

      logic [CNT_W-1:0] cnt_reg;
      logic             burst_start;

      // A rising valid starts a new burst that overwrites from address 0.
      assign burst_start  = in_valid_vec[gi] && !valid_prev_reg[gi];
      assign eff_vec[gi]  = burst_start ? '0 : cnt_reg;
      assign we_vec[gi]   = in_valid_vec[gi] && load_window && (eff_vec[gi] < LIMIT_C);
      assign over_vec[gi] = in_valid_vec[gi] && load_window && (eff_vec[gi] >= LIMIT_C);
      assign cnt_vec[gi]  = cnt_reg;

      // Count accepted words of this stream.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (PER_SAMPLE && clear_sample) begin
          cnt_reg <= '0;
        end else if (in_valid_vec[gi] && load_window) begin
          cnt_reg <= eff_vec[gi] + CNT_W'(we_vec[gi]);
        end
      end
    end
  endgenerate

  assign w1_we   = we_vec[0];
  assign w1_addr = eff_vec[0][W1_AW-1:0];
  assign w2_we   = we_vec[1];
  assign w2_addr = eff_vec[1][HID_W-1:0];
  assign d_we    = we_vec[2];
  assign d_addr  = eff_vec[2][IN_W-1:0];
  assign t_we    = we_vec[3];

  assign w1_full      = (cnt_vec[0] == CNT_W'(N_W1));
  assign w2_full      = (cnt_vec[1] == CNT_W'(N_HID));
  // Weights completed in the same cycle as the sample still count.
  assign weights_full = weights_ok_reg || (w1_full && w2_full);
  assign sample_ready = (cnt_vec[2] == CNT_W'(N_IN)) && (cnt_vec[3] == CNT_W'(1));

  assign fire    = op_valid && op_ready;
  assign res_hit = res_valid && outstanding_reg;
  assign busy    = !load_window;
  assign err     = err_reg;

  // Protocol violations are reported one cycle after they are seen.
  assign err_next = (|over_vec)
                  || (!load_window && (|in_valid_vec))
                  || (res_valid && !outstanding_reg)
                  || discard;

  // Next-state, op field and loop index logic.
  always_comb begin
    state_next   = state_reg;
    row_next     = row_reg;
    col_next     = col_reg;
    op_valid     = 1'b0;
    op_code      = 3'd0;
    op_row       = '0;
    op_col       = '0;
    op_first     = 1'b0;
    out_valid    = 1'b0;
    clear_sample = 1'b0;
    discard      = 1'b0;
    op_active    = 1'b0;
    op_matrix    = 1'b0;
    op_single    = 1'b0;
    code_sel     = 3'd0;
    first_sel    = 1'b0;
    after_state  = S_IDLE;
    phase_last   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (|in_valid_vec) state_next = S_LOAD;
      end
      S_LOAD: begin
        if (sample_ready) begin
          clear_sample = 1'b1;
          if (weights_full) begin
            state_next = S_FWD1;
          end else begin
            discard    = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      S_FWD1: begin
        op_active = 1'b1; op_matrix = 1'b1; code_sel = OP_MAC1;
        first_sel = (col_reg == '0); after_state = S_ACT;
      end
      S_ACT: begin
        op_active = 1'b1; code_sel = OP_ACT; after_state = S_FWD2;
      end
      S_FWD2: begin
        op_active = 1'b1; code_sel = OP_MAC2;
        first_sel = (row_reg == '0); after_state = S_OUT;
      end
      S_OUT: begin
        out_valid  = 1'b1;
        state_next = S_BWD_ERR;
      end
      S_BWD_ERR: begin
        op_active = 1'b1; op_single = 1'b1; code_sel = OP_ERR; after_state = S_UPD2;
      end
      S_UPD2: begin
        op_active = 1'b1; code_sel = OP_UPD2; after_state = S_UPD1;
      end
      S_UPD1: begin
        op_active = 1'b1; op_matrix = 1'b1; code_sel = OP_UPD1; after_state = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    phase_last = op_single || ((row_reg == ROW_LAST) && (!op_matrix || (col_reg == COL_LAST)));

    if (op_active) begin
      // Fields are presented only while no op is outstanding.
      if (!outstanding_reg) begin
        op_valid = 1'b1;
        op_code  = code_sel;
        op_row   = op_single ? '0 : row_reg;
        op_col   = op_matrix ? col_reg : '0;
        op_first = first_sel;
      end
      // Advance only on completion of the outstanding op.
      if (res_hit) begin
        if (phase_last) begin
          row_next   = '0;
          col_next   = '0;
          state_next = after_state;
        end else if (op_matrix && (col_reg != COL_LAST)) begin
          col_next = col_reg + 1'b1;
        end else begin
          col_next = '0;
          row_next = row_reg + 1'b1;
        end
      end
    end
  end

  // State, loop indices, handshake and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      row_reg         <= '0;
      col_reg         <= '0;
      outstanding_reg <= 1'b0;
      weights_ok_reg  <= 1'b0;
      err_reg         <= 1'b0;
      valid_prev_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      row_reg        <= row_next;
      col_reg        <= col_next;
      weights_ok_reg <= weights_ok_reg || (w1_full && w2_full);
      err_reg        <= err_next;
      valid_prev_reg <= in_valid_vec;
      if (fire) begin
        outstanding_reg <= 1'b1;
      end else if (res_hit) begin
        outstanding_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ann_seq_ctrl.sv
// Self-checking bench for ann_seq_ctrl: expected op sequences are pushed to a
// scoreboard when a sample is driven and compared as the DUT issues ops.
module tb_ann_seq_ctrl;

  localparam int N_IN      = 4;
  localparam int N_HID     = 3;
  localparam int N_OPS     = 2 * N_HID * N_IN + 3 * N_HID + 1;
  localparam int LAST_MAC2 = N_HID * N_IN + 2 * N_HID - 1;
  localparam int STALL_IDX = 6;

  localparam int SEL_W1 = 0;
  localparam int SEL_W2 = 1;
  localparam int SEL_D  = 2;
  localparam int SEL_T  = 3;

  logic       clk, rst;
  logic       in_valid_w1, in_valid_w2, in_valid_d, in_valid_t;
  logic       w1_we, w2_we, d_we, t_we;
  logic [3:0] w1_addr;
  logic [1:0] w2_addr, d_addr;
  logic       op_valid, op_ready, op_first, res_valid;
  logic [2:0] op_code;
  logic [1:0] op_row, op_col;
  logic       out_valid, busy, err;

  typedef struct packed {
    logic [2:0] code;
    logic [1:0] row;
    logic [1:0] col;
    logic       first;
  } op_t;

  op_t exp_q[$];

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  int sample_ops   = 0;
  int out_cnt      = 0;
  int err_cnt      = 0;
  int err_base     = 0;
  int first_op_cyc = -1;
  int out_exp_cyc  = -1;
  int last_drv_cyc = 0;
  int res_cd       = 0;
  int res_op_idx   = -1;
  int stall_left   = 0;
  bit stall_en     = 0;
  bit upd2_seen    = 0;

  ann_seq_ctrl #(.N_IN(N_IN), .N_HID(N_HID)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_w1(in_valid_w1),
    .in_valid_w2(in_valid_w2),
    .in_valid_d (in_valid_d),
    .in_valid_t (in_valid_t),
    .w1_we      (w1_we),
    .w1_addr    (w1_addr),
    .w2_we      (w2_we),
    .w2_addr    (w2_addr),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .t_we       (t_we),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .op_row     (op_row),
    .op_col     (op_col),
    .op_first   (op_first),
    .res_valid  (res_valid),
    .out_valid  (out_valid),
    .busy       (busy),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_compared++;
    if (got != exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference op order for one training step.
  task automatic push_sample();
    for (int h = 0; h < N_HID; h++)
      for (int i = 0; i < N_IN; i++)
        exp_q.push_back('{3'd0, 2'(h), 2'(i), (i == 0)});
    for (int h = 0; h < N_HID; h++) exp_q.push_back('{3'd1, 2'(h), 2'd0, 1'b0});
    for (int h = 0; h < N_HID; h++) exp_q.push_back('{3'd2, 2'(h), 2'd0, (h == 0)});
    exp_q.push_back('{3'd3, 2'd0, 2'd0, 1'b0});
    for (int h = 0; h < N_HID; h++) exp_q.push_back('{3'd4, 2'(h), 2'd0, 1'b0});
    for (int h = 0; h < N_HID; h++)
      for (int i = 0; i < N_IN; i++)
        exp_q.push_back('{3'd5, 2'(h), 2'(i), 1'b0});
  endtask

  task automatic set_valid(input int sel, input logic v);
    case (sel)
      SEL_W1:  in_valid_w1 = v;
      SEL_W2:  in_valid_w2 = v;
      SEL_D:   in_valid_d  = v;
      default: in_valid_t  = v;
    endcase
  endtask

  // Drive one burst and check strobe/address of every word.
  task automatic send_burst(input int sel, input int n, input int limit);
    int we_o, addr_o;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      set_valid(sel, 1'b1);
      #2;
      case (sel)
        SEL_W1:  begin we_o = int'(w1_we); addr_o = int'(w1_addr); end
        SEL_W2:  begin we_o = int'(w2_we); addr_o = int'(w2_addr); end
        SEL_D:   begin we_o = int'(d_we);  addr_o = int'(d_addr);  end
        default: begin we_o = int'(t_we);  addr_o = 0;             end
      endcase
      check_eq($sformatf("we_s%0d_w%0d", sel, k), we_o, (k < limit) ? 1 : 0);
      if (k < limit && sel != SEL_T) check_eq($sformatf("addr_s%0d_w%0d", sel, k), addr_o, k);
      last_drv_cyc = cyc;
    end
    @(negedge clk);
    set_valid(sel, 1'b0);
  endtask

  task automatic begin_sample(input bit expect_ops);
    sample_ops   = 0;
    out_cnt      = 0;
    first_op_cyc = -1;
    err_base     = err_cnt;
    if (expect_ops) push_sample();
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
    #2;
  endtask

  // Wait for a full step to finish and check its outcome.
  task automatic finish_sample(input string tag, input int exp_err);
    int guard = 0;
    while (!(sample_ops == N_OPS && busy == 1'b0 && res_cd == 0) && guard < 3000) begin
      @(negedge clk);
      #2;
      guard++;
    end
    check_eq({tag, "_done_in_time"}, (guard < 3000) ? 1 : 0, 1);
    check_eq({tag, "_op_count"}, sample_ops, N_OPS);
    check_eq({tag, "_queue_left"}, exp_q.size(), 0);
    check_eq({tag, "_out_pulses"}, out_cnt, 1);
    check_eq({tag, "_first_op_lat"}, first_op_cyc - last_drv_cyc, 2);
    check_eq({tag, "_err_pulses"}, err_cnt - err_base, exp_err);
    check_eq({tag, "_busy_end"}, int'(busy), 0);
  endtask

  // Monitor and datapath responder: accepts ops, answers 2 cycles later.
  initial begin
    op_t e;
    int  exp_v;
    res_valid = 1'b0;
    op_ready  = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      res_valid = 1'b0;
      if (res_cd > 0) begin
        res_cd--;
        if (res_cd == 0) begin
          res_valid = 1'b1;
          if (res_op_idx == LAST_MAC2) out_exp_cyc = cyc + 1;
        end
      end
      op_ready = 1'b1;
      if (stall_en && sample_ops == STALL_IDX && stall_left > 0 && (op_valid || stall_left < 5)) begin
        op_ready = 1'b0;
        stall_left--;
        check_eq("stall_op_valid", int'(op_valid), 1);
        check_eq("stall_op_row", int'(op_row), 1);
        check_eq("stall_op_col", int'(op_col), 2);
      end
      if (op_valid && first_op_cyc < 0) first_op_cyc = cyc;
      if (op_valid && op_ready) begin
        if (exp_q.size() > 0) begin
          e     = exp_q.pop_front();
          exp_v = int'(e);
        end else begin
          exp_v = -1;
        end
        check_eq($sformatf("op%0d", sample_ops), int'({op_code, op_row, op_col, op_first}), exp_v);
        $display("op %0d: code=%0d row=%0d col=%0d first=%0d", sample_ops, op_code, op_row, op_col, op_first);
        if (op_code == 3'd4) upd2_seen = 1'b1;
        res_op_idx = sample_ops;
        sample_ops++;
        res_cd = 2;
      end
      if (out_valid) begin
        out_cnt++;
        check_eq("out_valid_timing", cyc, out_exp_cyc);
      end
      if (err) err_cnt++;
    end
  end

  initial begin
    int guard;
    rst         = 1'b1;
    in_valid_w1 = 1'b0;
    in_valid_w2 = 1'b0;
    in_valid_d  = 1'b0;
    in_valid_t  = 1'b0;
    wait_cycles(3);
    rst = 1'b0;
    #1;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_op_valid", int'(op_valid), 0);
    check_eq("rst_err", int'(err), 0);
    check_eq("rst_out_valid", int'(out_valid), 0);

    // Sample without weights: discarded with one err pulse.
    begin_sample(1'b0);
    send_burst(SEL_D, 4, 4);
    send_burst(SEL_T, 1, 1);
    wait_cycles(6);
    check_eq("noweights_ops", sample_ops, 0);
    check_eq("noweights_err", err_cnt - err_base, 1);
    check_eq("noweights_busy", int'(busy), 0);

    // Load weights, then a sample with a 5-cycle op_ready stall on op 7.
    send_burst(SEL_W1, 12, 12);
    send_burst(SEL_W2, 3, 3);
    begin_sample(1'b1);
    stall_en   = 1'b1;
    stall_left = 5;
    send_burst(SEL_D, 4, 4);
    send_burst(SEL_T, 1, 1);
    finish_sample("s1", 0);
    check_eq("s1_stall_used", stall_left, 0);
    stall_en = 1'b0;

    // Second sample reuses retained weights; an input word while busy errs.
    begin_sample(1'b1);
    send_burst(SEL_D, 4, 4);
    send_burst(SEL_T, 1, 1);
    wait_cycles(8);
    @(negedge clk);
    in_valid_w1 = 1'b1;
    #2;
    check_eq("busy_w1_we", int'(w1_we), 0);
    @(negedge clk);
    in_valid_w1 = 1'b0;
    finish_sample("s2", 1);

    // Over-long data burst, then reset while a UPD2 op is outstanding.
    begin_sample(1'b1);
    upd2_seen = 1'b0;
    send_burst(SEL_D, 5, 4);
    wait_cycles(1);
    check_eq("overrun_err", err_cnt - err_base, 1);
    send_burst(SEL_T, 1, 1);
    guard = 0;
    while (!upd2_seen && guard < 1000) begin
      @(negedge clk);
      #2;
      guard++;
    end
    check_eq("upd2_reached", int'(upd2_seen), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    exp_q.delete();
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_op_valid", int'(op_valid), 0);
    check_eq("mid_rst_op_code", int'(op_code), 0);
    check_eq("mid_rst_op_row", int'(op_row), 0);
    check_eq("mid_rst_op_first", int'(op_first), 0);
    check_eq("mid_rst_out_valid", int'(out_valid), 0);
    check_eq("mid_rst_err", int'(err), 0);
    check_eq("mid_rst_d_addr", int'(d_addr), 0);
    sample_ops = 0;
    err_base   = err_cnt;
    wait_cycles(6);
    check_eq("stray_res_err", err_cnt - err_base, 1);
    check_eq("stray_res_no_op", sample_ops, 0);
    check_eq("stray_res_busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
